serial_display_receiver: RTL
============================

# serial_display_receiver

Receives the three-wire serial display stream (serial data, shift clock, latch) that the digital clock drives to its external shift registers, and rebuilds the parallel display frame inside the system clock domain. Used as the far-end model in the clock's system testbench, and as the input stage of a companion display/FPGA board. Checks every frame for bit count and stalls, and reports each accepted or rejected frame.

## Interface
Parameters:
- FRAME_BITS, 24, bits per frame (6 BCD digits HH:MM:SS, 4 bits each, most significant digit first)
- TIMEOUT_CYCLES, 1024, clk cycles with no shift-clock rising edge after which a partial frame is aborted

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- serial_in  input  1  serial data; the transmitter's serial_out
- sclk_in  input  1  shift clock; the transmitter's clk_out; data is sampled on its rising edge
- latch_in  input  1  latch strobe; the transmitter's latch_out; a rising edge ends the frame
- data_out  output  FRAME_BITS  last good frame; the first bit received is in bit FRAME_BITS-1
- frame_valid  output  1  one-cycle pulse when data_out is updated
- frame_error  output  1  one-cycle pulse when a frame is rejected
- busy  output  1  high while in SHIFT state

## Operation
- **Synchronization**
  - serial_in, sclk_in and latch_in each pass through a 2-FF synchronizer, reset to 0.
  - A third register per line holds the previous synchronized value.
  - sclk_rise = sync2 & ~prev on the sclk line; latch_rise is formed the same way.
  - serial_in uses the same pipeline depth, so the data bit sampled pairs with the sclk edge.
- **Shift register**
  - shreg is FRAME_BITS wide and reset to 0.
  - On sclk_rise: shreg <= {shreg[FRAME_BITS-2:0], serial_sync}.
- **Bit counter**
  - bit_cnt is clog2(FRAME_BITS+2) wide.
  - Increments on sclk_rise and saturates at FRAME_BITS+1. The saturated value marks overflow.
- **Timeout counter**
  - Cleared on every sclk_rise and on entry to IDLE.
  - Increments each cycle while in SHIFT.
- **FSM states: IDLE and SHIFT.**
  - IDLE, on sclk_rise: shift, bit_cnt <= 1, go to SHIFT.
  - IDLE, on latch_rise with no sclk_rise: empty frame. Pulse frame_error, stay in IDLE.
  - SHIFT, on sclk_rise: shift, increment bit_cnt.
  - SHIFT, on latch_rise: evaluate the frame, clear bit_cnt, go to IDLE.
  - SHIFT, when the timeout counter reaches TIMEOUT_CYCLES-1 without an edge: pulse frame_error, clear bit_cnt, go to IDLE. data_out is unchanged.
- **Frame evaluation**
  - Uses the next-state values of bit_cnt and shreg.
  - If bit_cnt_next == FRAME_BITS: data_out <= shreg_next and pulse frame_valid.
  - Otherwise, on short or overflow: pulse frame_error. data_out holds its value.
- **Simultaneous sclk_rise and latch_rise in one cycle**
  - The shift is applied first.
  - The latch then evaluates the frame including that bit.
- **Mutual exclusion:** frame_valid and frame_error are never high in the same cycle.
- **busy** = (state == SHIFT).
- **Reset values (asynchronous)**
  - state = IDLE; shreg, bit_cnt, timeout counter, synchronizers = 0.
  - data_out = 0, frame_valid = 0, frame_error = 0, busy = 0.
- **Reset mid-frame:** the partial frame is discarded with no pulse. The first frame after reset release must be complete to be accepted.

## Timing
- Let clk edge k be the first to sample a new level of any input.
  - sync2 updates at edge k+1.
  - The edge pulse is valid between k+1 and k+2.
  - The action registers at edge k+2.
- latch_in rising to data_out/frame_valid: 3 rising clk edges, counting edge k.
- frame_valid and frame_error are high for exactly 1 clk cycle.
- Input requirements on the transmitter:
  - sclk_in high and low phases each ≥ 3 clk periods.
  - serial_in stable from 2 clk periods before the sclk_in rise until 3 clk periods after it.
  - latch_in rises ≥ 3 clk periods after the last sclk_in rise, or coincides with it in the synchronized domain.
- No combinational path from any input to any output.

## Test plan
- **Good frame:** shift 0x123456 MSB first (sclk period 8 clk) then pulse latch → data_out = 0x123456, one frame_valid pulse exactly 3 edges after latch is sampled, busy drops in the same cycle.
- **Short and long frames:**
  - 23 bits then latch → frame_error pulse, data_out keeps its previous value 0x123456.
  - 25 bits then latch → frame_error pulse, bit_cnt had saturated at 25.
- **Timeout:** 10 bits, then sclk idle for 1024 clk → frame_error pulse, busy = 0. Then a full 0x090000 frame → data_out = 0x090000.
- **Coincident edges:** the 24th sclk rise and the latch rise are synchronized in the same clk cycle, data 0xABCDEF → data_out = 0xABCDEF, frame_valid pulse, no error.
- **Reset mid-frame:** assert reset asynchronously after 12 bits (between clk edges) → all outputs 0 immediately. After release, a full 0x000001 frame → data_out = 0x000001, no frame_error.
- **Empty latch:** latch pulse with no prior sclk in IDLE → frame_error pulse, data_out unchanged, state stays IDLE.

Source files
------------

// File: rtl/serial_display_receiver.sv
// serial_display_receiver: rebuilds the parallel display frame from the three-wire
// serial/shift-clock/latch stream, checking bit count and stalls per frame.
`default_nettype none

module serial_display_receiver #(
   parameter int FRAME_BITS     = 24,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_in,
   input  logic                  sclk_in,
   input  logic                  latch_in,
   output logic [FRAME_BITS-1:0] data_out,
   output logic                  frame_valid,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   // Per-line pipelines, bit 0 = serial, 1 = sclk, 2 = latch
   logic [2:0]            r_sync1;
   logic [2:0]            r_sync2;
   logic [2:0]            r_prev;

   state_t                r_state;
   logic [FRAME_BITS-1:0] r_shreg;
   logic [CNT_W-1:0]      r_cnt;
   logic [TO_W-1:0]       r_tcnt;
   logic [FRAME_BITS-1:0] r_data;
   logic                  r_valid;
   logic                  r_error;

   logic                  w_sclk_rise;
   logic                  w_latch_rise;
   logic [FRAME_BITS-1:0] w_shreg_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_frame_ok;
   logic                  w_timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= {latch_in, sclk_in, serial_in};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_sclk_rise  = r_sync2[1] & ~r_prev[1];
   assign w_latch_rise = r_sync2[2] & ~r_prev[2];

   // Shift lands before any latch evaluation in the same cycle
   assign w_shreg_next = w_sclk_rise ? {r_shreg[FRAME_BITS-2:0], r_sync2[0]} : r_shreg;

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_sclk_rise) begin
         if (r_state == S_IDLE) begin
            w_cnt_next = CNT_W'(1);
         end else if (r_cnt != CNT_W'(FRAME_BITS + 1)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
         end
      end
   end

   assign w_frame_ok = (w_cnt_next == CNT_W'(FRAME_BITS));
   assign w_timeout  = (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_tcnt  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_shreg <= w_shreg_next;
         case (r_state)
            S_IDLE: begin
               r_tcnt <= '0;
               if (w_latch_rise) begin
                  // Empty latch, or one bit coinciding with the latch
                  r_cnt <= '0;
                  if (w_frame_ok) begin
                     r_data  <= w_shreg_next;
                     r_valid <= 1'b1;
                  end else begin
                     r_error <= 1'b1;
                  end
               end else if (w_sclk_rise) begin
                  r_cnt   <= w_cnt_next;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_latch_rise) begin
                  r_cnt   <= '0;
                  r_tcnt  <= '0;
                  r_state <= S_IDLE;
                  if (w_frame_ok) begin
                     r_data  <= w_shreg_next;
                     r_valid <= 1'b1;
                  end else begin
                     r_error <= 1'b1;
                  end
               end else if (w_sclk_rise) begin
                  r_cnt  <= w_cnt_next;
                  r_tcnt <= '0;
               end else if (w_timeout) begin
                  r_cnt   <= '0;
                  r_tcnt  <= '0;
                  r_error <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + TO_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_tcnt  <= '0;
            end
         endcase
      end
   end

   assign data_out    = r_data;
   assign frame_valid = r_valid;
   assign frame_error = r_error;
   assign busy        = (r_state == S_SHIFT);

endmodule

`default_nettype wire
